dmem_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of the single-ported data memory. Port 0 serves the CPU core and port 1 serves the debug/DMA loader. The arbiter registers the winning request and drives the memory's E/WE/Addr/DataIn lines for exactly one cycle. It returns read data through a registered response with a valid strobe. This is the only block in the design that drives the data memory.

---
 rtl/dmem_arbiter_pkg.sv | 33 +++
 rtl/dmem_arbiter_if.sv | 56 +++++
 rtl/dmem_arbiter_rr_pick2.sv | 26 ++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Purpose  : Shared widths, FSM state encoding and command record for the
//            data-memory arbiter.
// Revision : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_DATA_W = 8;

    // Two-state sequencer: waiting for work, or driving one memory access.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // One registered memory access, owned by the port that won arbitration.
    typedef struct packed {
        logic                      port;
        logic                      we;
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] wdata;
    } cmd_t;

    // Port index to a two-bit one-hot vector (bit 0 = port 0).
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Bundle of both requester ports, the shared read response and the
//            data-memory control lines.
// Revision : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    // Port 0 (CPU core)
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    // Port 1 (debug/DMA loader)
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    // Shared read response
    logic [DATA_W-1:0] rdata;
    // Data memory side
    logic              mem_E;
    logic              mem_WE;
    logic [ADDR_W-1:0] mem_Addr;
    logic [DATA_W-1:0] mem_DataIn;
    logic [DATA_W-1:0] mem_DataOut;

    // Arbiter view
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_DataOut,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
        output mem_E, mem_WE, mem_Addr, mem_DataIn
    );

    // Requester and memory view
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_DataOut,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata,
        input  mem_E, mem_WE, mem_Addr, mem_DataIn
    );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_rr_pick2
// Purpose  : Combinational two-way round-robin picker. A masked requester is
//            ineligible; on a tie the port other than 'last' wins.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter_rr_pick2 (
    input  wire logic [1:0] req,
    input  wire logic [1:0] mask,
    input  wire logic       last,
    output logic            valid,
    output logic            winner
);

    logic [1:0] w_elig;

    // Eligible requests, then tie-break against the previous winner.
    always_comb begin
        w_elig = req & ~mask;
        valid  = |w_elig;
        winner = (&w_elig) ? ~last : w_elig[1];
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter and sequencer for the single-ported data
//            memory. Registers the winning request, drives the memory for one
//            cycle and returns read data through a registered response.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  wire logic      clk,
    input  wire logic      rst,
    dmem_arbiter_if.slave  bus
);

    state_t            r_state;
    state_t            w_next_state;
    cmd_t              r_cmd;
    logic              r_last;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rvalid;

    logic [1:0]        w_req;
    logic [1:0]        w_mask;
    logic              w_pick_valid;
    logic              w_pick_winner;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic [1:0]        w_gnt;
    logic              w_mem_e;
    logic              w_mem_we;

    // While an access is executing, its own port is masked so the other port
    // can be chained back-to-back and a lone requester cannot monopolise.
    always_comb begin
        w_req  = {bus.req1, bus.req0};
        w_mask = (r_state == ISSUE) ? port_onehot(r_cmd.port) : 2'b00;
    end

    dmem_arbiter_rr_pick2 u_pick (
        .req    (w_req),
        .mask   (w_mask),
        .last   (r_last),
        .valid  (w_pick_valid),
        .winner (w_pick_winner)
    );

    // Command fields of the selected port.
    always_comb begin
        w_sel_we    = w_pick_winner ? bus.we1    : bus.we0;
        w_sel_addr  = w_pick_winner ? bus.addr1  : bus.addr0;
        w_sel_wdata = w_pick_winner ? bus.wdata1 : bus.wdata0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: any new selection leads to (or stays in) ISSUE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_pick_valid ? ISSUE : IDLE;
            ISSUE:   w_next_state = w_pick_valid ? ISSUE : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from state and the registered command.
    always_comb begin
        w_gnt    = 2'b00;
        w_mem_e  = 1'b0;
        w_mem_we = 1'b0;
        if (r_state == ISSUE) begin
            w_gnt    = port_onehot(r_cmd.port);
            w_mem_e  = 1'b1;
            w_mem_we = r_cmd.we;
        end
    end

    // Command capture, round-robin pointer and registered read response.
    // A reset edge wins over a read finishing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd    <= '0;
            r_last   <= 1'b1;
            r_rdata  <= '0;
            r_rvalid <= 2'b00;
        end else begin
            r_rvalid <= 2'b00;
            if ((r_state == ISSUE) && !r_cmd.we) begin
                r_rdata  <= bus.mem_DataOut;
                r_rvalid <= port_onehot(r_cmd.port);
            end
            if (w_pick_valid) begin
                r_cmd.port  <= w_pick_winner;
                r_cmd.we    <= w_sel_we;
                r_cmd.addr  <= w_sel_addr;
                r_cmd.wdata <= w_sel_wdata;
                r_last      <= w_pick_winner;
            end
        end
    end

    assign bus.gnt0       = w_gnt[0];
    assign bus.gnt1       = w_gnt[1];
    assign bus.rvalid0    = r_rvalid[0];
    assign bus.rvalid1    = r_rvalid[1];
    assign bus.rdata      = r_rdata;
    assign bus.mem_E      = w_mem_e;
    assign bus.mem_WE     = w_mem_we;
    assign bus.mem_Addr   = r_cmd.addr;
    assign bus.mem_DataIn = r_cmd.wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a behavioural memory,
//            per-port requester agents and a transaction scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [7:0] wdata;
        int         lat;     // expected req-to-gnt cycles, 0 = not checked
    } op_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_edge = 1'b1;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] mem     [16];
    logic [7:0] ref_mem [16];
    op_t        opq [2][$];
    op_t        cq  [2][$];
    rd_t        rdq [2][$];
    int         exp_order[$];

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory: combinational read, write on the edge.
    assign bif.mem_DataOut = mem[bif.mem_Addr];
    always @(posedge clk) begin
        if (bif.mem_E && bif.mem_WE) mem[bif.mem_Addr] <= bif.mem_DataIn;
    end

    // Cycle count; a reset edge discards all outstanding expectations.
    always @(posedge clk) begin
        cyc++;
        rst_edge = rst;
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                cq[p].delete();
                rdq[p].delete();
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive(input int p, input bit r, input bit we, input logic [3:0] a, input logic [7:0] d);
        if (p == 0) begin
            bif.req0 = r; bif.we0 = we; bif.addr0 = a; bif.wdata0 = d;
        end else begin
            bif.req1 = r; bif.we1 = we; bif.addr1 = a; bif.wdata1 = d;
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? bif.gnt0 : bif.gnt1;
    endfunction

    // Requester agent: holds req until gnt, then presents its next op at once.
    task automatic run_port(input int p);
        op_t o;
        int  waited;
        bit  got;
        while (opq[p].size() > 0) begin
            o = opq[p].pop_front();
            drive(p, 1'b1, o.we, o.addr, o.wdata);
            cq[p].push_back(o);
            waited = 0;
            got    = 1'b0;
            while (!got && waited < 20) begin
                @(posedge clk); #2;
                waited++;
                if (gnt_of(p)) got = 1'b1;
            end
            if (!got) check_eq($sformatf("gnt%0d_timeout", p), 0, 1);
            else if (o.lat > 0) check_eq($sformatf("gnt%0d_latency", p), waited, o.lat);
        end
        drive(p, 1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    // Monitor: compares every cycle against the scoreboard.
    logic [1:0] g;
    logic [1:0] v;
    int         gp;
    op_t        mo;
    rd_t        mr;
    always @(negedge clk) begin
        g = {bif.gnt1, bif.gnt0};
        v = {bif.rvalid1, bif.rvalid0};
        if (rst_edge) begin
            check_eq("reset_outputs",
                     {g, v, bif.mem_E, bif.mem_WE, bif.mem_Addr, bif.mem_DataIn, bif.rdata}, 64'd0);
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (v[p]) begin
                    if (rdq[p].size() == 0) begin
                        check_eq($sformatf("rvalid%0d_spurious", p), 1, 0);
                    end else begin
                        mr = rdq[p].pop_front();
                        check_eq($sformatf("rdata_p%0d", p), bif.rdata, mr.data);
                        check_eq($sformatf("rvalid%0d_cycle", p), cyc, mr.due);
                    end
                end else if (rdq[p].size() > 0 && rdq[p][0].due <= cyc) begin
                    check_eq($sformatf("rvalid%0d_missing", p), 0, 1);
                    void'(rdq[p].pop_front());
                end
            end
            if (g == 2'b00) begin
                check_eq("idle_mem_e_we", {bif.mem_E, bif.mem_WE}, 0);
            end else if (g == 2'b11) begin
                check_eq("gnt_both", g, 2'b01);
            end else begin
                gp = g[1] ? 1 : 0;
                if (exp_order.size() > 0) check_eq("gnt_order", gp, exp_order.pop_front());
                if (cq[gp].size() == 0) begin
                    check_eq($sformatf("gnt%0d_spurious", gp), 1, 0);
                end else begin
                    mo = cq[gp].pop_front();
                    check_eq($sformatf("mem_cmd_p%0d", gp),
                             {bif.mem_E, bif.mem_WE, bif.mem_Addr, (mo.we ? bif.mem_DataIn : 8'h00)},
                             {1'b1, mo.we, mo.addr, (mo.we ? mo.wdata : 8'h00)});
                    if (mo.we) ref_mem[mo.addr] = mo.wdata;
                    else rdq[gp].push_back('{data: ref_mem[mo.addr], due: cyc + 1});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
        drive(0, 1'b1, 1'b1, 4'h1, 8'h11);   // request held through reset

        // Reset held two edges with req0 high, then first grant one cycle later.
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        opq[0].push_back('{we: 1'b1, addr: 4'h1, wdata: 8'h11, lat: 1});
        run_port(0);
        idle(2);

        // Single write then read on port 0.
        opq[0].push_back('{we: 1'b1, addr: 4'h3, wdata: 8'hA5, lat: 1});
        opq[0].push_back('{we: 1'b0, addr: 4'h3, wdata: 8'h00, lat: 2});
        run_port(0);
        idle(3);

        // Contention straight after reset: port 0 first, port 1 next cycle.
        do_reset();
        exp_order.push_back(0);
        exp_order.push_back(1);
        opq[0].push_back('{we: 1'b1, addr: 4'h5, wdata: 8'h55, lat: 1});
        opq[1].push_back('{we: 1'b1, addr: 4'h6, wdata: 8'h66, lat: 2});
        fork
            run_port(0);
            run_port(1);
        join
        idle(3);

        // Fairness: both hold requests, grants alternate starting with port 1.
        for (int i = 0; i < 3; i++) begin
            exp_order.push_back(1);
            exp_order.push_back(0);
            opq[1].push_back('{we: 1'b1, addr: 4'(8 + i), wdata: 8'(8'h80 + i), lat: (i == 0) ? 1 : 2});
            opq[0].push_back('{we: 1'b0, addr: 4'(8 + i), wdata: 8'h00, lat: (i == 0) ? 1 : 2});
        end
        fork
            run_port(1);
            begin
                @(posedge clk); #2;
                run_port(0);
            end
        join
        idle(3);

        // Write-then-read hazard: port 1 wins the tie, port 0 reads new data.
        exp_order.push_back(1);
        exp_order.push_back(0);
        opq[1].push_back('{we: 1'b1, addr: 4'h7, wdata: 8'h3C, lat: 1});
        opq[0].push_back('{we: 1'b0, addr: 4'h7, wdata: 8'h00, lat: 2});
        fork
            run_port(0);
            run_port(1);
        join
        idle(3);

        // Reset during the ISSUE cycle of a read: the response must vanish.
        drive(0, 1'b1, 1'b0, 4'h3, 8'h00);
        cq[0].push_back('{we: 1'b0, addr: 4'h3, wdata: 8'h00, lat: 0});
        @(posedge clk); #2;
        check_eq("midrst_gnt0", bif.gnt0, 1);
        drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        idle(3);

        // Random mixed traffic on both ports.
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < 2; p++) begin
                opq[p].push_back('{we: 1'($urandom_range(0, 1)), addr: 4'($urandom_range(0, 15)),
                                   wdata: 8'($urandom_range(0, 255)), lat: 0});
            end
        end
        fork
            run_port(0);
            run_port(1);
        join
        idle(4);

        check_eq("pending_at_end", cq[0].size() + cq[1].size() + rdq[0].size() + rdq[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
